// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one nibble and one digit select per slot,
// with frame-aligned display updates, per-digit masking and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pscnt_q, pscnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic                    pend_q, pend_d;
    logic [3:0]              nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fdone_q;

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   zero_above;

    assign tick = (pscnt_q == PS_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    always_comb begin
        pscnt_d    = tick ? '0 : pscnt_q + PW'(1);
        idx_d      = idx_q;
        if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (wrap) begin
            pend_d = 1'b0;
            if (load)        disp_d = data_in;
            else if (pend_q) disp_d = pend_val_q;
        end else if (load) begin
            pend_val_d = data_in;
            pend_d     = 1'b1;
        end
    end

    // zero_above[k]: every nibble of the new display value from k upward is zero
    always_comb begin
        logic z;
        z          = 1'b1;
        zero_above = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            z             = z && (disp_d[4*k +: 4] == 4'h0);
            zero_above[k] = z;
        end
    end

    always_comb begin
        logic blank;
        nib_d = nib_q;
        sel_d = sel_q;
        blank = lz_en && (idx_d != '0) && zero_above[idx_d];
        if (tick) begin
            nib_d = disp_d[{idx_d, 2'b00} +: 4];
            sel_d = (digit_en[idx_d] && !blank) ? (NUM_DIGITS'(1) << idx_d) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pscnt_q    <= '0;
            idx_q      <= IDX_LAST;
            disp_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            nib_q      <= 4'h0;
            sel_q      <= '0;
            fdone_q    <= 1'b0;
        end else begin
            pscnt_q    <= pscnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            nib_q      <= nib_d;
            sel_q      <= sel_d;
            fdone_q    <= wrap;
        end
    end

    assign nibble_out = nib_q;
    assign dig_sel    = sel_q;
    assign frame_done = fdone_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits and a 4-cycle slot.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst, load, lz_en;
    logic [15:0]   data_in;
    logic [3:0]    digit_en;
    logic [3:0]    nibble_out;
    logic [3:0]    dig_sel;
    logic          frame_done;

    int n_chk  = 0;
    int n_pass = 0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .digit_en(digit_en), .lz_en(lz_en),
        .nibble_out(nibble_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input logic [3:0] sel, input logic [3:0] nib);
        chk({tag, ".sel"}, 32'(dig_sel), 32'(sel));
        chk({tag, ".nib"}, 32'(nibble_out), 32'(nib));
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; data_in = v;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; digit_en = 4'hF; lz_en = 1'b0;
        step(2);
        slot("rst", 4'b0000, 4'h0);
        chk("rst.fd", 32'(frame_done), 0);
        rst = 1'b0;

        // first frame after reset
        step(3); slot("pre_wrap", 4'b0000, 4'h0);
        step(1); slot("wrap0", 4'b0001, 4'h0);
        chk("wrap0.fd", 32'(frame_done), 1);
        step(1); chk("fd_pulse", 32'(frame_done), 0);
        step(3); slot("f0.d1", 4'b0010, 4'h0);

        // load mid-frame during idx=1: old nibbles until wrap
        do_load(16'h1234);
        step(3); slot("old.d2", 4'b0100, 4'h0);
        step(4); slot("old.d3", 4'b1000, 4'h0);
        step(4); slot("new.d0", 4'b0001, 4'h4);
        chk("new.fd", 32'(frame_done), 1);
        step(4); slot("new.d1", 4'b0010, 4'h3);
        step(4); slot("new.d2", 4'b0100, 4'h2);
        step(4); slot("new.d3", 4'b1000, 4'h1);

        // two loads before wrap: last one wins
        do_load(16'hAAAA);
        do_load(16'h5678);
        step(2); slot("lw.d0", 4'b0001, 4'h8);
        step(4); slot("lw.d1", 4'b0010, 4'h7);
        step(4); slot("lw.d2", 4'b0100, 4'h6);
        step(4); slot("lw.d3", 4'b1000, 4'h5);

        // load on the wrap cycle bypasses straight into the display
        step(3);
        do_load(16'hBEEF);
        slot("byp.d0", 4'b0001, 4'hF);
        chk("byp.fd", 32'(frame_done), 1);
        step(4); slot("byp.d1", 4'b0010, 4'hE);
        step(4); slot("byp.d2", 4'b0100, 4'hE);
        step(4); slot("byp.d3", 4'b1000, 4'hB);
        step(4); slot("byp.next", 4'b0001, 4'hF);

        // leading-zero blanking
        lz_en = 1'b1;
        do_load(16'h0050);
        step(15); slot("lz.d0", 4'b0001, 4'h0);
        step(4);  slot("lz.d1", 4'b0010, 4'h5);
        step(4);  slot("lz.d2", 4'b0000, 4'h0);
        step(4);  slot("lz.d3", 4'b0000, 4'h0);
        do_load(16'h0000);
        step(3);  slot("lz0.d0", 4'b0001, 4'h0);
        step(4);  slot("lz0.d1", 4'b0000, 4'h0);

        // digit mask, nibble still carried on dark slots
        lz_en = 1'b0; digit_en = 4'b1010;
        do_load(16'h4321);
        step(3); slot("msk.d2", 4'b0000, 4'h0);
        step(4); slot("msk.d3", 4'b1000, 4'h0);
        step(4); slot("msk.d0", 4'b0000, 4'h1);
        step(4); slot("msk.d1", 4'b0010, 4'h2);
        step(4); slot("msk.d2b", 4'b0000, 4'h3);

        // reset mid-frame with a pending value
        digit_en = 4'hF;
        do_load(16'h9999);
        rst = 1'b1;
        step(1);
        slot("mrst", 4'b0000, 4'h0);
        chk("mrst.fd", 32'(frame_done), 0);
        rst = 1'b0;
        step(3); slot("mrst.pre", 4'b0000, 4'h0);
        step(1); slot("mrst.d0", 4'b0001, 4'h0);
        chk("mrst.fd2", 32'(frame_done), 1);
        step(4); slot("mrst.d1", 4'b0010, 4'h0);
        step(4); slot("mrst.d2", 4'b0100, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
